// File: rtl/pixel_rescaler_if.sv
// Pixel stream and extremes-load bundle between the max/min search block,
// the rescaler and the display pixel sink.
interface pixel_rescaler_if #(
    parameter int NB_PIXEL = 19,
    parameter int NB_COUNT = 32,
    parameter int NB_OUT   = 8
);
    logic                       i_loadExtremes;
    logic signed [NB_PIXEL-1:0] i_maxValue;
    logic signed [NB_PIXEL-1:0] i_minValue;
    logic [NB_COUNT-1:0]        i_imageSize;
    logic                       i_valid;
    logic signed [NB_PIXEL-1:0] i_convValue;
    logic                       o_ready;
    logic                       o_valid;
    logic [NB_OUT-1:0]          o_pixel;
    logic                       o_done;

    modport master (
        output i_loadExtremes, i_maxValue, i_minValue, i_imageSize, i_valid, i_convValue,
        input  o_ready, o_valid, o_pixel, o_done
    );

    modport slave (
        input  i_loadExtremes, i_maxValue, i_minValue, i_imageSize, i_valid, i_convValue,
        output o_ready, o_valid, o_pixel, o_done
    );
endinterface

// File: rtl/pixel_rescaler.sv
// Linear min/max rescaler: a serial divider derives a per-image scale factor,
// then a 3-stage pipeline maps each convolution value to an 8-bit pixel.
module pixel_rescaler #(
    parameter int NB_PIXEL = 19,
    parameter int NB_COUNT = 32,
    parameter int NB_FRAC  = 20,
    parameter int NB_OUT   = 8
) (
    input  logic           clock,
    input  logic           reset,
    pixel_rescaler_if.slave bus
);
    localparam int NB_RANGE   = NB_PIXEL + 1;
    localparam int NB_DIFF    = NB_PIXEL + 2;
    localparam int NB_QUO     = NB_FRAC + NB_OUT;
    localparam int NB_PROD    = NB_RANGE + NB_QUO;
    localparam int NB_DIV_CNT = $clog2(NB_QUO);

    localparam logic [NB_QUO-1:0]     DIVIDEND = {{NB_OUT{1'b1}}, {NB_FRAC{1'b0}}};
    localparam logic [NB_PROD:0]      ROUND    = {{(NB_PROD-NB_FRAC+1){1'b0}}, 1'b1, {(NB_FRAC-1){1'b0}}};
    localparam logic [NB_OUT-1:0]     FULL     = {NB_OUT{1'b1}};
    localparam logic [NB_DIV_CNT-1:0] DIV_LAST = NB_DIV_CNT'(NB_QUO - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                     state_r;
    logic signed [NB_PIXEL-1:0] min_r;
    logic [NB_RANGE-1:0]        range_r;
    logic [NB_COUNT-1:0]        size_r;
    logic [NB_COUNT-1:0]        count_r;
    logic [NB_DIV_CNT-1:0]      div_cnt_r;
    logic [NB_QUO-1:0]          dividend_r;
    logic [NB_RANGE-1:0]        rem_r;
    logic [NB_QUO-2:0]          quo_r;
    logic [NB_QUO-1:0]          scale_r;
    logic                       ready_r;
    logic                       done_r;

    logic signed [NB_PIXEL-1:0] x0_r;
    logic [NB_RANGE-1:0]        d_r;
    logic [NB_PROD-1:0]         p_r;
    logic [NB_OUT-1:0]          pixel_r;
    logic                       v0_r;
    logic                       v1_r;
    logic                       v2_r;
    logic                       valid_r;

    logic signed [NB_DIFF-1:0]  load_diff_s;
    logic [NB_RANGE-1:0]        load_range_s;
    logic [NB_RANGE:0]          rem_shift_s;
    logic [NB_RANGE-1:0]        rem_next_s;
    logic                       quo_bit_s;
    logic [NB_QUO-1:0]          quo_next_s;
    logic                       accept_s;
    logic                       last_s;
    logic                       pipe_empty_s;
    logic signed [NB_DIFF-1:0]  diff_s;
    logic [NB_RANGE-1:0]        clamp_s;
    logic [NB_PROD-1:0]         prod_s;
    logic [NB_PROD:0]           sum_s;
    logic [NB_OUT-1:0]          round_s;
    logic                       round_unused_s;

    // Range of the incoming extremes; a non-positive range collapses to zero.
    always_comb begin
        load_diff_s = NB_DIFF'(bus.i_maxValue) - NB_DIFF'(bus.i_minValue);
        if (load_diff_s > $signed({NB_DIFF{1'b0}})) begin
            load_range_s = load_diff_s[NB_RANGE-1:0];
        end else begin
            load_range_s = {NB_RANGE{1'b0}};
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_r, dividend_r[NB_QUO-1]};
        if (rem_shift_s >= {1'b0, range_r}) begin
            quo_bit_s  = 1'b1;
            rem_next_s = rem_shift_s[NB_RANGE-1:0] - range_r;
        end else begin
            quo_bit_s  = 1'b0;
            rem_next_s = rem_shift_s[NB_RANGE-1:0];
        end
        quo_next_s = {quo_r, quo_bit_s};
    end

    // Accept handshake and drain detection.
    always_comb begin
        accept_s     = ready_r & bus.i_valid;
        last_s       = accept_s && ((count_r + NB_COUNT'(1)) == size_r);
        pipe_empty_s = ~(v0_r | v1_r | v2_r);
    end

    // Pipeline datapath: offset/clamp, scale, round and saturate.
    always_comb begin
        diff_s = NB_DIFF'(x0_r) - NB_DIFF'(min_r);
        if (diff_s[NB_DIFF-1]) begin
            clamp_s = {NB_RANGE{1'b0}};
        end else if (diff_s > $signed({1'b0, range_r})) begin
            clamp_s = range_r;
        end else begin
            clamp_s = diff_s[NB_RANGE-1:0];
        end
        prod_s = NB_PROD'(d_r) * NB_PROD'(scale_r);
        sum_s  = {1'b0, p_r} + ROUND;
        if (|sum_s[NB_PROD:NB_FRAC+NB_OUT]) begin
            round_s = FULL;
        end else begin
            round_s = sum_s[NB_FRAC+NB_OUT-1:NB_FRAC];
        end
        round_unused_s = ^sum_s[NB_FRAC-1:0];
    end

    // Control FSM with the serial divider and accept counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            min_r      <= {NB_PIXEL{1'b0}};
            range_r    <= {NB_RANGE{1'b0}};
            size_r     <= {NB_COUNT{1'b0}};
            count_r    <= {NB_COUNT{1'b0}};
            div_cnt_r  <= {NB_DIV_CNT{1'b0}};
            dividend_r <= {NB_QUO{1'b0}};
            rem_r      <= {NB_RANGE{1'b0}};
            quo_r      <= {(NB_QUO-1){1'b0}};
            scale_r    <= {NB_QUO{1'b0}};
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (bus.i_loadExtremes) begin
                        min_r      <= bus.i_minValue;
                        range_r    <= load_range_s;
                        size_r     <= bus.i_imageSize;
                        count_r    <= {NB_COUNT{1'b0}};
                        div_cnt_r  <= {NB_DIV_CNT{1'b0}};
                        dividend_r <= DIVIDEND;
                        rem_r      <= {NB_RANGE{1'b0}};
                        quo_r      <= {(NB_QUO-1){1'b0}};
                        state_r    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    ready_r    <= 1'b0;
                    rem_r      <= rem_next_s;
                    quo_r      <= quo_next_s[NB_QUO-2:0];
                    dividend_r <= {dividend_r[NB_QUO-2:0], 1'b0};
                    div_cnt_r  <= div_cnt_r + NB_DIV_CNT'(1);
                    if (div_cnt_r == DIV_LAST) begin
                        // A zero range would leave an all-ones quotient; pin the scale to 0.
                        scale_r <= (range_r == {NB_RANGE{1'b0}}) ? {NB_QUO{1'b0}} : quo_next_s;
                        state_r <= (size_r == {NB_COUNT{1'b0}}) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    ready_r <= ~last_s;
                    if (accept_s) begin
                        count_r <= count_r + NB_COUNT'(1);
                    end
                    if (last_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    ready_r <= 1'b0;
                    if (done_r) begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (pipe_empty_s) begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Capture register plus three processing stages; valid bits travel alongside.
    always_ff @(posedge clock) begin
        if (reset) begin
            x0_r    <= {NB_PIXEL{1'b0}};
            d_r     <= {NB_RANGE{1'b0}};
            p_r     <= {NB_PROD{1'b0}};
            pixel_r <= {NB_OUT{1'b0}};
            v0_r    <= 1'b0;
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            v0_r    <= accept_s;
            v1_r    <= v0_r;
            v2_r    <= v1_r;
            valid_r <= v2_r;
            if (accept_s) begin
                x0_r <= bus.i_convValue;
            end
            if (v0_r) begin
                d_r <= clamp_s;
            end
            if (v1_r) begin
                p_r <= prod_s;
            end
            if (v2_r) begin
                pixel_r <= round_s;
            end
        end
    end

    assign bus.o_ready = ready_r;
    assign bus.o_valid = valid_r;
    assign bus.o_pixel = pixel_r;
    assign bus.o_done  = done_r;

endmodule

// File: tb/tb_pixel_rescaler.sv
// Directed bench for pixel_rescaler: expected pixels go to a scoreboard when
// driven and are compared, with their arrival cycle, when o_valid appears.
module tb_pixel_rescaler;
    localparam int NB_PIXEL = 19;
    localparam int NB_COUNT = 32;
    localparam int NB_FRAC  = 20;
    localparam int NB_OUT   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pixel_rescaler_if #(.NB_PIXEL(NB_PIXEL), .NB_COUNT(NB_COUNT), .NB_OUT(NB_OUT)) bus ();

    pixel_rescaler #(
        .NB_PIXEL(NB_PIXEL), .NB_COUNT(NB_COUNT), .NB_FRAC(NB_FRAC), .NB_OUT(NB_OUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pix;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: round((x-min)*255/(max-min)) via the same fixed-point recipe.
    function automatic int model(input int mn, input int mx, input int x);
        longint r, s, d, q;
        r = longint'(mx) - longint'(mn);
        if (r > 0) s = (longint'(255) * (longint'(1) << NB_FRAC)) / r;
        else       s = 0;
        d = longint'(x) - longint'(mn);
        if (d < 0) d = 0;
        if (d > r) d = r;
        q = (d * s + (longint'(1) << (NB_FRAC - 1))) / (longint'(1) << NB_FRAC);
        if (q > 255) q = 255;
        return int'(q);
    endfunction

    // Output monitor: pops the scoreboard on every o_valid.
    always @(negedge clock) begin
        exp_t e;
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious o_valid", {31'd0, bus.o_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pixel", {24'd0, bus.o_pixel}, e.pix);
                check("latency", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("missing o_valid", {31'd0, bus.o_valid}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int mn, input int mx, input int size, input bit noise);
        bus.i_minValue     = NB_PIXEL'(mn);
        bus.i_maxValue     = NB_PIXEL'(mx);
        bus.i_imageSize    = NB_COUNT'(size);
        bus.i_loadExtremes = 1'b1;
        tick();
        bus.i_loadExtremes = 1'b0;
        bus.i_valid        = noise;
        bus.i_convValue    = NB_PIXEL'(77);
        repeat (NB_FRAC + 8) tick();
        check("ready low in divide", {31'd0, bus.o_ready}, 32'd0);
        tick();
        bus.i_valid = 1'b0;
        if (size > 0) begin
            check("ready after divide", {31'd0, bus.o_ready}, 32'd1);
        end else begin
            check("empty image done", {31'd0, bus.o_done}, 32'd1);
            check("empty image ready", {31'd0, bus.o_ready}, 32'd0);
            tick();
            check("empty image done end", {31'd0, bus.o_done}, 32'd0);
        end
    endtask

    task automatic send(input int x, input int expv);
        bus.i_valid     = 1'b1;
        bus.i_convValue = NB_PIXEL'(x);
        sb.push_back('{pix: expv, due: cyc + 4});
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic gap();
        tick();
        check("ready in gap", {31'd0, bus.o_ready}, 32'd1);
    endtask

    task automatic finish_image(input int last_pix);
        check("ready falls", {31'd0, bus.o_ready}, 32'd0);
        repeat (4) tick();
        check("done pulse", {31'd0, bus.o_done}, 32'd1);
        check("pixel hold", {24'd0, bus.o_pixel}, last_pix);
        check("scoreboard drained", sb.size(), 32'd0);
        tick();
        check("done ends", {31'd0, bus.o_done}, 32'd0);
        check("idle ready", {31'd0, bus.o_ready}, 32'd0);
    endtask

    initial begin
        bus.i_loadExtremes = 1'b0;
        bus.i_maxValue     = '0;
        bus.i_minValue     = '0;
        bus.i_imageSize    = '0;
        bus.i_valid        = 1'b0;
        bus.i_convValue    = '0;
        reset = 1'b1;
        tick();
        tick();
        check("reset o_ready", {31'd0, bus.o_ready}, 32'd0);
        check("reset o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("reset o_pixel", {24'd0, bus.o_pixel}, 32'd0);
        check("reset o_done", {31'd0, bus.o_done}, 32'd0);
        reset = 1'b0;
        tick();

        // Unit scale factor.
        load(-100, 155, 4, 1'b0);
        send(-100, 0);
        send(27, 127);
        send(155, 255);
        send(0, 100);
        finish_image(100);

        // Half scale: rounding of .5 values.
        load(0, 510, 3, 1'b0);
        send(255, 128);
        send(1, 1);
        send(509, 255);
        finish_image(255);

        // Clamping; i_valid held high through DIVIDE must be dropped.
        load(0, 100, 2, 1'b1);
        send(-5, 0);
        send(200, 255);
        finish_image(255);

        // Degenerate extremes.
        load(42, 42, 2, 1'b0);
        send(42, 0);
        send(100, 0);
        finish_image(0);

        // Empty image.
        load(5, 900, 0, 1'b0);
        repeat (5) tick();

        // Gapped valid 1,0,1,1,0,1 with a stray load in the second gap.
        load(-1000, 3000, 4, 1'b0);
        send(-1000, model(-1000, 3000, -1000));
        gap();
        send(1000, model(-1000, 3000, 1000));
        send(3000, model(-1000, 3000, 3000));
        bus.i_minValue     = NB_PIXEL'(0);
        bus.i_maxValue     = NB_PIXEL'(1);
        bus.i_imageSize    = NB_COUNT'(1);
        bus.i_loadExtremes = 1'b1;
        gap();
        bus.i_loadExtremes = 1'b0;
        send(2500, model(-1000, 3000, 2500));
        finish_image(model(-1000, 3000, 2500));

        // Reset mid-image after 2 of 5 pixels.
        load(10, 20, 5, 1'b0);
        send(12, model(10, 20, 12));
        send(15, model(10, 20, 15));
        bus.i_valid     = 1'b1;
        bus.i_convValue = NB_PIXEL'(18);
        reset = 1'b1;
        sb.delete();
        tick();
        check("mid reset o_ready", {31'd0, bus.o_ready}, 32'd0);
        check("mid reset o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("mid reset o_pixel", {24'd0, bus.o_pixel}, 32'd0);
        check("mid reset o_done", {31'd0, bus.o_done}, 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("idle after reset", {31'd0, bus.o_ready}, 32'd0);
        bus.i_valid = 1'b0;

        // Fresh image after reset, wide range.
        load(-200000, 200000, 3, 1'b0);
        send(-200000, model(-200000, 200000, -200000));
        send(0, model(-200000, 200000, 0));
        send(199999, model(-200000, 200000, 199999));
        finish_image(model(-200000, 200000, 199999));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
